alu_in_arbiter: RTL

Packet-granular round-robin arbiter that shares the multi-cycle ALU operand input port among NUM_REQ requesters. It sits directly in front of the ALU input port (operand_valid/op/a/b/operand_last/ready). It grants one requester at a time and holds that grant until the requester's operand_last beat is accepted by the ALU, so operand streams from different requesters are never interleaved.

---
 rtl/alu_in_arbiter.sv | 70 +++++++
 1 files changed

// File: rtl/alu_in_arbiter.sv
// alu_in_arbiter: packet-granular round-robin arbiter in front of the ALU operand port
module alu_in_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OPERAND_BUS_WIDTH = 8,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [3*NUM_REQ-1:0]                 req_op,
  input  logic [OPERAND_BUS_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [OPERAND_BUS_WIDTH*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]                   req_last,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 alu_operand_valid,
  output logic [2:0]                           alu_op,
  output logic [OPERAND_BUS_WIDTH-1:0]         alu_a,
  output logic [OPERAND_BUS_WIDTH-1:0]         alu_b,
  output logic                                 alu_operand_last,
  input  logic                                 alu_ready,
  output logic                                 grant_valid,
  output logic [IDW-1:0]                       grant_id,
  output logic                                 pkt_done
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic [IDW-1:0] rr_ptr, win, idx;
  logic lock;
  assign lock = state == LOCK;
  assign grant_valid = lock;
  // scan downwards from rr_ptr+NUM_REQ-1 so the lowest offset from rr_ptr wins last
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) win = idx;
    end
  end
  // operand mux from the locked requester; everything idles at zero when unlocked
  always_comb begin
    alu_operand_valid = lock ? req_valid[grant_id] : 1'b0;
    alu_operand_last = lock ? req_last[grant_id] : 1'b0;
    alu_op = lock ? 3'(req_op >> (3 * grant_id)) : '0;
    alu_a = lock ? OPERAND_BUS_WIDTH'(req_a >> (OPERAND_BUS_WIDTH * grant_id)) : '0;
    alu_b = lock ? OPERAND_BUS_WIDTH'(req_b >> (OPERAND_BUS_WIDTH * grant_id)) : '0;
    req_ready = lock ? NUM_REQ'(alu_ready) << grant_id : '0;
  end
  // grant on any request in IDLE, release once the locked requester's last beat is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant_id <= '0;
      rr_ptr <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (!lock) begin
        if (|req_valid) begin
          state <= LOCK;
          grant_id <= win;
          rr_ptr <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
      end else if (alu_operand_valid && alu_ready && req_last[grant_id]) begin
        state <= IDLE;
        pkt_done <= 1'b1;
      end
    end
  end
endmodule
